credit_output_scheduler: RTL and testbench

- Per-output-channel scheduler for the wormhole switch.
- Arbitrates among IN_N input buffers with round-robin and locks the output channel to the winning input until that packet's tail flit has left.
- Gates every flit transfer on a credit counter that mirrors free slots in the downstream node's input buffer. This replaces the rdy/vld backpressure path with credit-based flow control.

---
 rtl/credit_output_scheduler.sv | 110 +++++++++++
 tb/tb_credit_output_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_output_scheduler.sv
// Per-output-channel scheduler: round-robin input arbitration with packet lock,
// and credit-based flow control toward the downstream input buffer.
module credit_output_scheduler #(
   parameter  int unsigned IN_N    = 5,
   parameter  int unsigned CREDITS = 4,
   localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IN_N-1:0]  req_i,
   input  logic [IN_N-1:0]  flit_vld_i,
   input  logic [IN_N-1:0]  flit_is_tail_i,
   output logic [IN_N-1:0]  grant_o,
   output logic [IN_N-1:0]  rd_o,
   output logic             oc_vld_o,
   input  logic             credit_ret_i,
   output logic [CNT_W-1:0] credit_cnt_o,
   output logic             busy_o,
   output logic             ovf_o
);

   typedef enum logic {IDLE, ALLOC} state_t;

   state_t           r_state;
   logic [IN_N-1:0]  r_grant;
   logic             r_busy;
   logic [IN_N-1:0]  r_mask;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic [IN_N-1:0]  w_elig;
   logic [IN_N-1:0]  w_masked;
   logic [IN_N-1:0]  w_win;
   logic             w_xfer;
   logic             w_tail;

   assign w_elig   = req_i & flit_vld_i;
   assign w_masked = w_elig & r_mask;

   // Pointer kept as a mask of inputs at or above it; an empty masked set wraps to bit 0.
   always_comb begin
      w_win = '0;
      if (w_masked != '0)
         w_win = w_masked & (~w_masked + IN_N'(1));
      else
         w_win = w_elig & (~w_elig + IN_N'(1));
   end

   assign w_xfer = (|(r_grant & flit_vld_i)) & (r_cnt != '0);
   assign w_tail = |(r_grant & flit_is_tail_i);

   assign grant_o      = r_grant;
   assign rd_o         = w_xfer ? r_grant : '0;
   assign oc_vld_o     = w_xfer;
   assign busy_o       = r_busy;
   assign credit_cnt_o = r_cnt;
   assign ovf_o        = r_ovf;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_mask  <= '1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_elig != '0) begin
                  r_state <= ALLOC;
                  r_grant <= w_win;
                  r_busy  <= 1'b1;
               end
            end
            ALLOC: begin
               if (w_xfer && w_tail) begin
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  // Inputs strictly above the owner; owner IN_N-1 yields 0, i.e. wrap to input 0.
                  r_mask  <= ~((r_grant << 1) - IN_N'(1));
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= CNT_W'(CREDITS);
         r_ovf <= 1'b0;
      end else begin
         case ({w_xfer, credit_ret_i})
            2'b10: r_cnt <= r_cnt - CNT_W'(1);
            2'b01: begin
               if (r_cnt == CNT_W'(CREDITS))
                  r_ovf <= 1'b1;
               else
                  r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_credit_output_scheduler.sv
// Directed and randomized checks of credit_output_scheduler against a
// cycle-level reference model of the arbitration and credit rules.
module tb_credit_output_scheduler;

   localparam int N  = 5;
   localparam int CR = 4;
   localparam int CW = $clog2(CR + 1);

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [N-1:0]  req_i = '0;
   logic [N-1:0]  flit_vld_i = '0;
   logic [N-1:0]  flit_is_tail_i = '0;
   logic          credit_ret_i = 1'b0;
   logic [N-1:0]  grant_o;
   logic [N-1:0]  rd_o;
   logic          oc_vld_o;
   logic [CW-1:0] credit_cnt_o;
   logic          busy_o;
   logic          ovf_o;

   credit_output_scheduler #(.IN_N(N), .CREDITS(CR)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .flit_vld_i     (flit_vld_i),
      .flit_is_tail_i (flit_is_tail_i),
      .grant_o        (grant_o),
      .rd_o           (rd_o),
      .oc_vld_o       (oc_vld_o),
      .credit_ret_i   (credit_ret_i),
      .credit_cnt_o   (credit_cnt_o),
      .busy_o         (busy_o),
      .ovf_o          (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   // reference model: owning input (-1 = none), RR pointer, credits, sticky overflow
   int m_own;
   int m_ptr;
   int m_cnt;
   bit m_ovf;

   logic prev_busy;
   logic [N-1:0] grant_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = -1;
      m_ptr = 0;
      m_cnt = CR;
      m_ovf = 1'b0;
      prev_busy = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      req_i = '0; flit_vld_i = '0; flit_is_tail_i = '0; credit_ret_i = 1'b0;
      #1;
      chk("rst_grant", grant_o, 0);
      chk("rst_rd", rd_o, 0);
      chk("rst_ocvld", oc_vld_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_cnt", credit_cnt_o, CR);
      chk("rst_ovf", ovf_o, 0);
      model_reset();
      #3;
      rst_ni = 1'b1;
   endtask

   task automatic step(input logic [N-1:0] rq, input logic [N-1:0] vl,
                       input logic [N-1:0] tl, input logic rt);
      logic [N-1:0] egr;
      logic [N-1:0] erd;
      bit xf;
      bit found;
      int was;
      @(negedge clk_i);
      req_i = rq; flit_vld_i = vl; flit_is_tail_i = tl; credit_ret_i = rt;
      #1;
      egr = (m_own < 0) ? '0 : (N'(1) << m_own);
      xf  = (m_own >= 0) && vl[m_own] && (m_cnt > 0);
      erd = xf ? egr : '0;
      chk("grant", grant_o, egr);
      chk("rd", rd_o, erd);
      chk("oc_vld", oc_vld_o, xf);
      chk("busy", busy_o, (m_own >= 0));
      chk("cnt", credit_cnt_o, m_cnt);
      chk("ovf", ovf_o, m_ovf);
      if (busy_o && !prev_busy) grant_log.push_back(grant_o);
      prev_busy = busy_o;
      was = m_own;
      if (was < 0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && rq[i] && vl[i]) begin
               m_own = i;
               found = 1'b1;
            end
         end
      end else if (xf && tl[was]) begin
         m_ptr = (was + 1) % N;
         m_own = -1;
      end
      m_cnt = m_cnt - int'(xf) + int'(rt);
      if (m_cnt > CR) begin
         m_cnt = CR;
         m_ovf = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      do_reset();

      // single requester, 3-flit packet from input 2
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      chk("sr_grant_c1", grant_o, 5'b00100);
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      step(5'b00100, 5'b00100, 5'b00100, 1'b0);
      step(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("sr_cnt", credit_cnt_o, 1);
      chk("sr_idle", busy_o, 0);

      // round robin among inputs 0,1,4 with 1-flit packets
      do_reset();
      grant_log.delete();
      for (int c = 0; c < 12; c++) step(5'b10011, 5'b10011, 5'b11111, 1'b1);
      chk("rr_count", grant_log.size(), 6);
      if (grant_log.size() >= 6) begin
         logic [N-1:0] exp_ord[6];
         exp_ord = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};
         for (int j = 0; j < 6; j++) chk("rr_order", grant_log[j], exp_ord[j]);
      end

      // credit starvation: 6-flit packet from input 2, no returns
      do_reset();
      for (int c = 0; c < 8; c++) step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      chk("st_cnt0", credit_cnt_o, 0);
      chk("st_hold", grant_o, 5'b00100);
      chk("st_stall", oc_vld_o, 0);
      step(5'b00100, 5'b00100, 5'b00000, 1'b1);
      chk("st_ret_blocked", oc_vld_o, 0);
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      chk("st_resume", oc_vld_o, 1);
      step(5'b00100, 5'b00100, 5'b00000, 1'b1);
      step(5'b00100, 5'b00100, 5'b00100, 1'b1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b0);

      // simultaneous return and transfer, then overflow
      do_reset();
      step(5'b00010, 5'b00010, 5'b00000, 1'b0);
      step(5'b00010, 5'b00010, 5'b00000, 1'b0);
      step(5'b00010, 5'b00010, 5'b00000, 1'b0);
      step(5'b00010, 5'b00010, 5'b00000, 1'b1);
      chk("sim_cnt", credit_cnt_o, 2);
      step(5'b00000, 5'b00010, 5'b00010, 1'b1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("ovf_cnt", credit_cnt_o, CR);
      chk("ovf_set", ovf_o, 1);
      step(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("ovf_sticky", ovf_o, 1);

      // lock hold: input 3 requests during input 0's packet
      do_reset();
      step(5'b00001, 5'b00001, 5'b00000, 1'b1);
      step(5'b00001, 5'b00001, 5'b00000, 1'b1);
      step(5'b01001, 5'b01001, 5'b00000, 1'b1);
      chk("lock_flit2", grant_o, 5'b00001);
      step(5'b01001, 5'b01001, 5'b00000, 1'b1);
      step(5'b01001, 5'b01001, 5'b00001, 1'b1);
      step(5'b01001, 5'b01001, 5'b01000, 1'b1);
      chk("lock_gap", busy_o, 0);
      step(5'b01001, 5'b01001, 5'b01000, 1'b1);
      chk("lock_next", grant_o, 5'b01000);
      step(5'b01001, 5'b01001, 5'b01000, 1'b1);
      step(5'b00001, 5'b00001, 5'b00001, 1'b1);

      // asynchronous reset mid-packet
      do_reset();
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      step(5'b00100, 5'b00100, 5'b00000, 1'b0);
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("ar_grant", grant_o, 0);
      chk("ar_rd", rd_o, 0);
      chk("ar_cnt", credit_cnt_o, CR);
      chk("ar_busy", busy_o, 0);
      model_reset();
      #1;
      rst_ni = 1'b1;

      // randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] rq, vl, tl;
         logic rt;
         rq = N'($urandom);
         vl = N'($urandom) | N'($urandom);
         tl = N'($urandom) & N'($urandom);
         rt = ($urandom_range(0, 2) == 0);
         step(rq, vl, tl, rt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
